memory_access_unit: RTL and testbench
=====================================

// Module: memory_access_unit
// PURPOSE
//  Memory-stage consumer of the EX/MEM pipeline register outputs. Turns em_* load/store controls into
//  a req/ack data-memory bus transaction with byte enables, sign-extends load data, and drives the MEM/WB
//  register. Stalls upstream while a transaction is in flight. A timeout counter flags hung buses.
// PARAMETERS
//  BUS_TIMEOUT  255  REQ-state cycles without dmem_ack_i before bus error (1..255, 8-bit counter)
// PORTS
//  clk_i                 in   1   clock, rising edge
//  reset_ni              in   1   reset, asynchronous, active-low
//  em_reg_write_i        in   1   register-file write enable from EX/MEM
//  em_mem_read_i         in   1   load request
//  em_mem_write_i        in   1   store request
//  em_dmem_to_reg_i      in   2   writeback source select (passed through)
//  em_funct3_i           in   3   access size/sign: 0 B, 1 H, 2 W, 4 BU, 5 HU
//  em_write_addr_reg_i   in   5   destination register
//  em_alu_result_i       in   32  effective address / ALU result
//  em_read_data2_i       in   32  store data
//  dmem_req_o            out  1   bus request, registered, held until ack
//  dmem_we_o             out  1   1 = store
//  dmem_addr_o           out  32  byte address
//  dmem_be_o             out  4   byte enables
//  dmem_wdata_o          out  32  store data, lane-replicated
//  dmem_ack_i            in   1   bus completion; rdata valid same cycle
//  dmem_rdata_i          in   32  load word
//  mem_stall_o           out  1   upstream must hold em_* inputs stable
//  bus_err_o             out  1   one-cycle pulse on timeout
//  misalign_o            out  1   one-cycle pulse on misaligned access (only with macro)
//  mw_reg_write_o        out  1   MEM/WB register outputs ...
//  mw_dmem_to_reg_o      out  2
//  mw_write_addr_reg_o   out  5
//  mw_alu_result_o       out  32
//  mw_load_data_o        out  32  sign/zero-extended load result
// BEHAVIOUR
//  - Reset (async, reset_ni=0): state IDLE, timeout counter 0, every output 0. Mid-transaction reset drops
//    dmem_req_o immediately; no MEM/WB update.
//  - FSM IDLE/REQ. IDLE, no access: mw_* capture em_* each edge (1-cycle latency), mw_load_data_o=0.
//  - IDLE, access (mem_read|mem_write): mem_stall_o=1 combinationally; next edge -> REQ with dmem_req_o=1,
//    dmem_we_o, addr, be, wdata registered. mw_reg_write_o=0 while the access is outstanding (bubble).
//  - REQ: mem_stall_o=1 unless dmem_ack_i=1. On ack: mem_stall_o=0 in that cycle; edge captures mw_*,
//    load data formatted from dmem_rdata_i using registered addr[1:0]; dmem_req_o=0; -> IDLE.
//    Minimum load/store occupancy: 2 cycles.
//  - Simultaneous mem_read and mem_write: treated as store; load data 0.
//  - Byte enables: B 4'b0001<<addr[1:0]; H 4'b0011<<{addr[1],1'b0}; W 4'b1111. Store data: B replicated
//    x4, H replicated x2. Load: B/H sign-extend, BU/HU zero-extend, W unchanged. Reserved funct3 (3,6,7)
//    acts as W.
//  - Timeout: counter increments each REQ cycle without ack, clears on leaving REQ. At BUS_TIMEOUT:
//    bus_err_o=1 for one cycle, dmem_req_o=0, mw_reg_write_o forced 0, mw_load_data_o=0, stall released,
//    -> IDLE. An ack arriving on the timeout cycle wins; there is no error in that case.
// CONFIGURATION
//  MISALIGN_TRAP_EN defined: H with addr[0]=1, or W with addr[1:0]!=0, issues no bus request and causes
//  no stall. misalign_o pulses 1 on the capturing edge, mw_reg_write_o=0.
//  MISALIGN_TRAP_EN undefined: misalign_o tied 0. Low address bits are masked: H clears addr[0], W clears
//  addr[1:0], for dmem_addr_o, be, and lane select.
// TESTING
//  1. Reset low mid-REQ -> dmem_req_o=0 at once; all outputs 0; IDLE after release.
//  2. LB addr 0x1003, rdata 0x80FF_FF00, ack 1st REQ cycle -> be=4'b1000, mw_load_data_o=0xFFFF_FF80,
//     stall 2 cycles.
//  3. SH addr 0x2002, data 0x1234_ABCD, ack after 3 cycles -> be=4'b1100, wdata=0xABCD_ABCD, stall held
//     until ack, mw_reg_write_o=0.
//  4. Non-memory op x=7, alu 0x55 back-to-back -> mw_* follow one cycle later, no stall, no dmem_req_o.
//  5. LW, ack never, BUS_TIMEOUT=4 -> bus_err_o pulse after 4 REQ cycles, mw_reg_write_o=0, next op
//     accepted.
//  6. LW addr 0x3001: with MISALIGN_TRAP_EN -> misalign_o=1, no req. Without it -> dmem_addr_o=0x3000,
//     be=4'b1111.

Source files
------------

// File: rtl/memory_access_unit.sv
// memory_access_unit
//   Memory stage of the pipeline. Consumes the EX/MEM register outputs, turns load/store
//   controls into a req/ack data-memory transaction (byte enables, lane-replicated store
//   data), formats returned load data and drives the MEM/WB register. Upstream is stalled
//   while a transaction is outstanding; a REQ-state timeout counter flags a hung bus.
//
// Parameters
//   BUS_TIMEOUT  REQ cycles without ack before a bus error (1..255)
//
// Configuration macro
//   MISALIGN_TRAP_EN  defined: misaligned H/W accesses issue no bus request and pulse
//                     misalign_o. Undefined: misalign_o tied 0 and low address bits are
//                     masked (H clears addr[0], W clears addr[1:0]).
//
// Ports
//   clk_i, reset_ni            clock (rising edge), asynchronous active-low reset
//   em_*_i                     EX/MEM register outputs (controls, address, store data)
//   dmem_req_o/we_o/addr_o/be_o/wdata_o   registered bus request, held until ack
//   dmem_ack_i, dmem_rdata_i   bus completion, read data valid in the ack cycle
//   mem_stall_o                combinational: upstream must hold em_* stable
//   bus_err_o                  one-cycle pulse on timeout
//   misalign_o                 one-cycle pulse on a trapped misaligned access
//   mw_*_o                     MEM/WB register outputs

module memory_access_unit #(
  parameter int unsigned BUS_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        reset_ni,
  input  logic        em_reg_write_i,
  input  logic        em_mem_read_i,
  input  logic        em_mem_write_i,
  input  logic [1:0]  em_dmem_to_reg_i,
  input  logic [2:0]  em_funct3_i,
  input  logic [4:0]  em_write_addr_reg_i,
  input  logic [31:0] em_alu_result_i,
  input  logic [31:0] em_read_data2_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        mem_stall_o,
  output logic        bus_err_o,
  output logic        misalign_o,
  output logic        mw_reg_write_o,
  output logic [1:0]  mw_dmem_to_reg_o,
  output logic [4:0]  mw_write_addr_reg_o,
  output logic [31:0] mw_alu_result_o,
  output logic [31:0] mw_load_data_o
);

  typedef enum logic [0:0] {StIdle, StReq} state_e;

  // Counter value on the last permitted REQ cycle without ack.
  localparam logic [7:0] TmoLast = 8'(BUS_TIMEOUT - 1);

  state_e      state_q;
  logic [7:0]  tmo_cnt_q;
  logic        load_q;
  logic [2:0]  funct3_q;

  logic        access;
  logic        is_load;
  logic        size_b;
  logic        size_h;
  logic        size_w;
  logic        misalign_hit;
  logic [31:0] eff_addr;
  logic [3:0]  be_d;
  logic [31:0] wdata_d;
  logic        tmo_hit;
  logic [7:0]  lane_byte;
  logic [15:0] lane_half;
  logic [31:0] load_fmt;

  assign access  = em_mem_read_i | em_mem_write_i;
  // Read and write together is a store.
  assign is_load = em_mem_read_i & ~em_mem_write_i;

  // funct3[1:0]: 00 byte, 01 half, 1x word (reserved 3/6/7 fall into word).
  assign size_b = (em_funct3_i[1:0] == 2'b00);
  assign size_h = (em_funct3_i[1:0] == 2'b01);
  assign size_w = em_funct3_i[1];

`ifdef MISALIGN_TRAP_EN
  logic misalign_q;

  assign misalign_hit = (size_h & em_alu_result_i[0]) | (size_w & (|em_alu_result_i[1:0]));
  // Misaligned accesses never reach the bus, so no masking is needed.
  assign eff_addr     = em_alu_result_i;
  assign misalign_o   = misalign_q;
`else
  assign misalign_hit = 1'b0;
  assign misalign_o   = 1'b0;

  always_comb begin
    eff_addr = em_alu_result_i;
    if (size_w) begin
      eff_addr[1:0] = 2'b00;
    end else if (size_h) begin
      eff_addr[0] = 1'b0;
    end
  end
`endif

  always_comb begin
    be_d    = 4'b1111;
    wdata_d = em_read_data2_i;
    if (size_b) begin
      be_d    = 4'b0001 << eff_addr[1:0];
      wdata_d = {4{em_read_data2_i[7:0]}};
    end else if (size_h) begin
      be_d    = 4'b0011 << {eff_addr[1], 1'b0};
      wdata_d = {2{em_read_data2_i[15:0]}};
    end
  end

  // An ack in the same cycle takes precedence over the timeout.
  assign tmo_hit = (state_q == StReq) && !dmem_ack_i && (tmo_cnt_q == TmoLast);

  always_comb begin
    if (state_q == StIdle) begin
      mem_stall_o = access & ~misalign_hit;
    end else begin
      mem_stall_o = ~(dmem_ack_i | tmo_hit);
    end
  end

  // Load formatting uses the registered (already masked) lane address.
  always_comb begin
    lane_byte = dmem_rdata_i[7:0];
    case (dmem_addr_o[1:0])
      2'd0: lane_byte = dmem_rdata_i[7:0];
      2'd1: lane_byte = dmem_rdata_i[15:8];
      2'd2: lane_byte = dmem_rdata_i[23:16];
      2'd3: lane_byte = dmem_rdata_i[31:24];
      default: lane_byte = dmem_rdata_i[7:0];
    endcase
    lane_half = dmem_addr_o[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
    case (funct3_q)
      3'd0:    load_fmt = {{24{lane_byte[7]}}, lane_byte};
      3'd1:    load_fmt = {{16{lane_half[15]}}, lane_half};
      3'd4:    load_fmt = {24'h0, lane_byte};
      3'd5:    load_fmt = {16'h0, lane_half};
      default: load_fmt = dmem_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q             <= StIdle;
      tmo_cnt_q           <= 8'd0;
      load_q              <= 1'b0;
      funct3_q            <= 3'd0;
      dmem_req_o          <= 1'b0;
      dmem_we_o           <= 1'b0;
      dmem_addr_o         <= 32'd0;
      dmem_be_o           <= 4'd0;
      dmem_wdata_o        <= 32'd0;
      bus_err_o           <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q          <= 1'b0;
`endif
      mw_reg_write_o      <= 1'b0;
      mw_dmem_to_reg_o    <= 2'd0;
      mw_write_addr_reg_o <= 5'd0;
      mw_alu_result_o     <= 32'd0;
      mw_load_data_o      <= 32'd0;
    end else begin
      bus_err_o <= 1'b0;
`ifdef MISALIGN_TRAP_EN
      misalign_q <= 1'b0;
`endif
      case (state_q)
        StIdle: begin
          tmo_cnt_q           <= 8'd0;
          mw_dmem_to_reg_o    <= em_dmem_to_reg_i;
          mw_write_addr_reg_o <= em_write_addr_reg_i;
          mw_alu_result_o     <= em_alu_result_i;
          mw_load_data_o      <= 32'd0;
          if (access && !misalign_hit) begin
            // Launch the transaction; MEM/WB sees a bubble until completion.
            state_q        <= StReq;
            dmem_req_o     <= 1'b1;
            dmem_we_o      <= em_mem_write_i;
            dmem_addr_o    <= eff_addr;
            dmem_be_o      <= be_d;
            dmem_wdata_o   <= wdata_d;
            load_q         <= is_load;
            funct3_q       <= em_funct3_i;
            mw_reg_write_o <= 1'b0;
          end else if (access) begin
`ifdef MISALIGN_TRAP_EN
            misalign_q     <= 1'b1;
`endif
            mw_reg_write_o <= 1'b0;
          end else begin
            mw_reg_write_o <= em_reg_write_i;
          end
        end
        StReq: begin
          if (dmem_ack_i) begin
            state_q             <= StIdle;
            tmo_cnt_q           <= 8'd0;
            dmem_req_o          <= 1'b0;
            mw_reg_write_o      <= em_reg_write_i;
            mw_dmem_to_reg_o    <= em_dmem_to_reg_i;
            mw_write_addr_reg_o <= em_write_addr_reg_i;
            mw_alu_result_o     <= em_alu_result_i;
            mw_load_data_o      <= load_q ? load_fmt : 32'd0;
          end else if (tmo_hit) begin
            state_q             <= StIdle;
            tmo_cnt_q           <= 8'd0;
            dmem_req_o          <= 1'b0;
            bus_err_o           <= 1'b1;
            mw_reg_write_o      <= 1'b0;
            mw_dmem_to_reg_o    <= em_dmem_to_reg_i;
            mw_write_addr_reg_o <= em_write_addr_reg_i;
            mw_alu_result_o     <= em_alu_result_i;
            mw_load_data_o      <= 32'd0;
          end else begin
            tmo_cnt_q      <= tmo_cnt_q + 8'd1;
            mw_reg_write_o <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_memory_access_unit.sv
// Scoreboard bench for memory_access_unit (BUS_TIMEOUT = 4). The driver pushes expected
// bus requests and MEM/WB results; two monitors pop and compare when the DUT issues a
// request or retires an operation.

module tb_memory_access_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        em_reg_write, em_mem_read, em_mem_write;
  logic [1:0]  em_dmem_to_reg;
  logic [2:0]  em_funct3;
  logic [4:0]  em_write_addr_reg;
  logic [31:0] em_alu_result, em_read_data2;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        mem_stall, bus_err, misalign;
  logic        mw_reg_write;
  logic [1:0]  mw_dmem_to_reg;
  logic [4:0]  mw_write_addr_reg;
  logic [31:0] mw_alu_result, mw_load_data;

  always #5 clk = ~clk;

  memory_access_unit #(.BUS_TIMEOUT(4)) dut (
    .clk_i              (clk),
    .reset_ni           (reset_n),
    .em_reg_write_i     (em_reg_write),
    .em_mem_read_i      (em_mem_read),
    .em_mem_write_i     (em_mem_write),
    .em_dmem_to_reg_i   (em_dmem_to_reg),
    .em_funct3_i        (em_funct3),
    .em_write_addr_reg_i(em_write_addr_reg),
    .em_alu_result_i    (em_alu_result),
    .em_read_data2_i    (em_read_data2),
    .dmem_req_o         (dmem_req),
    .dmem_we_o          (dmem_we),
    .dmem_addr_o        (dmem_addr),
    .dmem_be_o          (dmem_be),
    .dmem_wdata_o       (dmem_wdata),
    .dmem_ack_i         (dmem_ack),
    .dmem_rdata_i       (dmem_rdata),
    .mem_stall_o        (mem_stall),
    .bus_err_o          (bus_err),
    .misalign_o         (misalign),
    .mw_reg_write_o     (mw_reg_write),
    .mw_dmem_to_reg_o   (mw_dmem_to_reg),
    .mw_write_addr_reg_o(mw_write_addr_reg),
    .mw_alu_result_o    (mw_alu_result),
    .mw_load_data_o     (mw_load_data)
  );

  typedef struct packed {
    logic        rw;
    logic [1:0]  d2r;
    logic [4:0]  rd;
    logic [31:0] alu;
    logic [31:0] ld;
  } mw_t;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } bus_t;

  mw_t  mw_q[$];
  bus_t bus_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic track = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // MEM/WB monitor: an operation retires on an edge where the tracked op is not stalled.
  initial begin
    mw_t e;
    forever begin
      @(posedge clk);
      if (reset_n && track && !mem_stall) begin
        #2;
        if (mw_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL mw_unexpected: got retire want none");
        end else begin
          e = mw_q.pop_front();
          check("mw", {mw_reg_write, mw_dmem_to_reg, mw_write_addr_reg, mw_alu_result,
                       mw_load_data}, e);
        end
      end
    end
  end

  // Bus monitor: checks each newly raised request.
  initial begin
    logic req_prev;
    bus_t e;
    req_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (dmem_req && !req_prev) begin
        if (bus_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL bus_unexpected: got req addr %h want none", dmem_addr);
        end else begin
          e = bus_q.pop_front();
          check("bus", {dmem_we, dmem_addr, dmem_be, dmem_wdata}, e);
        end
      end
      req_prev = dmem_req;
    end
  end

  task automatic em_idle();
    em_reg_write = 0; em_mem_read = 0; em_mem_write = 0; em_dmem_to_reg = 0;
    em_funct3 = 0; em_write_addr_reg = 0; em_alu_result = 0; em_read_data2 = 0;
  endtask

  // Called at posedge+1. ack_after: REQ cycle number carrying ack (0 = never).
  task automatic run_op(input logic rd_en, input logic wr_en, input logic rw,
                        input logic [1:0] d2r, input logic [2:0] f3, input logic [4:0] rd,
                        input logic [31:0] alu, input logic [31:0] wd,
                        input int ack_after, input logic [31:0] rdata,
                        input logic exp_rw, input logic [31:0] exp_ld,
                        input logic bus_v, input logic [31:0] exp_addr,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input int exp_occ, input string name);
    int occ;
    int reqc;
    logic done;
    em_reg_write = rw; em_mem_read = rd_en; em_mem_write = wr_en; em_dmem_to_reg = d2r;
    em_funct3 = f3; em_write_addr_reg = rd; em_alu_result = alu; em_read_data2 = wd;
    if (bus_v) bus_q.push_back({wr_en, exp_addr, exp_be, exp_wdata});
    mw_q.push_back({exp_rw, d2r, rd, alu, exp_ld});
    track = 1'b1;
    occ = 0;
    reqc = 0;
    done = 1'b0;
    while (!done && occ < 40) begin
      @(negedge clk);
      occ++;
      if (dmem_req) begin
        reqc++;
        if (reqc == ack_after) begin
          dmem_ack = 1'b1;
          dmem_rdata = rdata;
        end
      end
      #1;
      done = !mem_stall;
      @(posedge clk);
      #1;
      dmem_ack = 1'b0;
      dmem_rdata = 32'd0;
    end
    track = 1'b0;
    em_idle();
    check({name, "_occupancy"}, 128'(occ), 128'(exp_occ));
  endtask

  initial begin
    reset_n = 1'b0;
    dmem_ack = 1'b0;
    dmem_rdata = 32'd0;
    em_idle();
    #3;
    check("reset_bus", {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata}, 128'd0);
    check("reset_mw", {mem_stall, bus_err, misalign, mw_reg_write, mw_dmem_to_reg,
                       mw_write_addr_reg, mw_alu_result, mw_load_data}, 128'd0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Non-memory ops back to back: 1-cycle latency, no stall, no request.
    run_op(0, 0, 1, 2'b00, 3'd0, 5'd7, 32'h55, 32'h0, 0, 32'h0,
           1, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, "alu_x7");
    run_op(0, 0, 1, 2'b10, 3'd0, 5'd8, 32'hAA, 32'h0, 0, 32'h0,
           1, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, "alu_x8");
    // LB 0x1003, ack on first REQ cycle.
    run_op(1, 0, 1, 2'b01, 3'd0, 5'd5, 32'h1003, 32'h0, 1, 32'h80FF_FF00,
           1, 32'hFFFF_FF80, 1, 32'h1003, 4'b1000, 32'h0, 2, "lb");
    // SH 0x2002, ack on third REQ cycle.
    run_op(0, 1, 0, 2'b00, 3'd1, 5'd0, 32'h2002, 32'h1234_ABCD, 3, 32'h0,
           0, 32'h0, 1, 32'h2002, 4'b1100, 32'hABCD_ABCD, 4, "sh");
    run_op(1, 0, 1, 2'b01, 3'd1, 5'd10, 32'h12, 32'h0, 1, 32'hF00D_1234,
           1, 32'hFFFF_F00D, 1, 32'h12, 4'b1100, 32'h0, 2, "lh");
    run_op(1, 0, 1, 2'b01, 3'd5, 5'd11, 32'h2002, 32'h0, 2, 32'h8765_4321,
           1, 32'h0000_8765, 1, 32'h2002, 4'b1100, 32'h0, 3, "lhu");
    run_op(1, 0, 1, 2'b01, 3'd4, 5'd12, 32'h1001, 32'h0, 1, 32'h0000_AB00,
           1, 32'h0000_00AB, 1, 32'h1001, 4'b0010, 32'h0, 2, "lbu");
    run_op(1, 0, 1, 2'b01, 3'd2, 5'd13, 32'h40, 32'h0, 1, 32'hDEAD_BEEF,
           1, 32'hDEAD_BEEF, 1, 32'h40, 4'b1111, 32'h0, 2, "lw");
    run_op(0, 1, 0, 2'b00, 3'd0, 5'd0, 32'h5001, 32'h0000_0077, 1, 32'h0,
           0, 32'h0, 1, 32'h5001, 4'b0010, 32'h7777_7777, 2, "sb");
    // Read and write together: store, load data 0.
    run_op(1, 1, 0, 2'b00, 3'd2, 5'd0, 32'h60, 32'hCAFE_F00D, 1, 32'h1111_1111,
           0, 32'h0, 1, 32'h60, 4'b1111, 32'hCAFE_F00D, 2, "rw_both");

    // Timeout: no ack for 4 REQ cycles.
    run_op(1, 0, 1, 2'b01, 3'd2, 5'd9, 32'h80, 32'h0, 0, 32'h0,
           0, 32'h0, 1, 32'h80, 4'b1111, 32'h0, 5, "lw_timeout");
    check("tmo_bus_err", {bus_err, dmem_req}, {1'b1, 1'b0});
    run_op(0, 0, 1, 2'b00, 3'd0, 5'd14, 32'h99, 32'h0, 0, 32'h0,
           1, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, "after_tmo");
    check("tmo_pulse_end", 128'(bus_err), 128'd0);
    // Ack on the timeout cycle wins.
    run_op(1, 0, 1, 2'b01, 3'd2, 5'd15, 32'h84, 32'h0, 4, 32'h0BAD_F00D,
           1, 32'h0BAD_F00D, 1, 32'h84, 4'b1111, 32'h0, 5, "lw_ack_edge");
    check("ack_edge_no_err", 128'(bus_err), 128'd0);

`ifdef MISALIGN_TRAP_EN
    run_op(1, 0, 1, 2'b01, 3'd2, 5'd3, 32'h3001, 32'h0, 0, 32'h0,
           0, 32'h0, 0, 32'h0, 4'h0, 32'h0, 1, "lw_mis_trap");
    check("misalign_pulse", {misalign, dmem_req}, {1'b1, 1'b0});
`else
    run_op(1, 0, 1, 2'b01, 3'd2, 5'd3, 32'h3001, 32'h0, 1, 32'h1122_3344,
           1, 32'h1122_3344, 1, 32'h3000, 4'b1111, 32'h0, 2, "lw_mis_mask");
    check("misalign_tied", 128'(misalign), 128'd0);
    run_op(1, 0, 1, 2'b01, 3'd1, 5'd4, 32'h2001, 32'h0, 1, 32'h1234_8001,
           1, 32'hFFFF_8001, 1, 32'h2000, 4'b0011, 32'h0, 2, "lh_mis_mask");
`endif

    // Asynchronous reset in the middle of a REQ cycle.
    em_reg_write = 1; em_mem_read = 1; em_funct3 = 3'd2; em_write_addr_reg = 5'd6;
    em_alu_result = 32'h100;
    bus_q.push_back({1'b0, 32'h100, 4'b1111, 32'h0});
    @(negedge clk);
    @(negedge clk);
    check("req_before_reset", 128'(dmem_req), 128'd1);
    #2;
    reset_n = 1'b0;
    em_idle();
    #1;
    check("reset_drop_req", 128'(dmem_req), 128'd0);
    check("reset_bus2", {dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata}, 128'd0);
    check("reset_mw2", {mem_stall, bus_err, misalign, mw_reg_write, mw_dmem_to_reg,
                        mw_write_addr_reg, mw_alu_result, mw_load_data}, 128'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check("idle_after_reset", {dmem_req, mem_stall}, 128'd0);
    run_op(1, 0, 1, 2'b01, 3'd2, 5'd16, 32'h200, 32'h0, 1, 32'h0C0F_FEE0,
           1, 32'h0C0F_FEE0, 1, 32'h200, 4'b1111, 32'h0, 2, "lw_post_reset");

    repeat (3) @(posedge clk);
    check("queues_drained", {96'd0, 16'(mw_q.size()), 16'(bus_q.size())}, 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
